// File: rtl/digit_serial_add_sub.sv
// Digit-serial N-bit add/subtract, D bits per cycle LSD first, with cout/ovf/zero flags.
// Latency: N/D cycles from the accepting edge to out_valid.
// Backpressure: result is held in DONE until out_ready; in_ready is low in RUN and DONE.
//
// Ports:
//   clk, rst             clock and asynchronous active-high reset
//   in_valid/in_ready    operand handshake for a, b, cin, op (op: 0 add, 1 subtract)
//   out_valid/out_ready  result handshake for sum, cout, ovf, zero
module digit_serial_add_sub #(
  parameter int N = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int NDIG = N / D;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   a_q, b_q;
  logic           carry_q;
  logic [CW-1:0]  cnt_q;

  logic [D-1:0]   a_dig, b_dig, dig_sum;
  logic           dig_cout;
  logic           carry_into_msb;
  logic [N-1:0]   sum_nxt;
  logic           last_dig;

  // Digit datapath: select digit cnt_q, add with the running carry, and
  // merge the result digit into the held sum.
  always_comb begin
    a_dig   = '0;
    b_dig   = '0;
    sum_nxt = sum;
    for (int k = 0; k < NDIG; k++) begin
      if (cnt_q == CW'(k)) begin
        a_dig = a_q[k*D +: D];
        b_dig = b_q[k*D +: D];
      end
    end
    {dig_cout, dig_sum} = {1'b0, a_dig} + {1'b0, b_dig} + {{D{1'b0}}, carry_q};
    // The carry into the digit MSB is recovered from its sum bit: s = a ^ b ^ c.
    carry_into_msb = dig_sum[D-1] ^ a_dig[D-1] ^ b_dig[D-1];
    for (int k = 0; k < NDIG; k++) begin
      if (cnt_q == CW'(k)) begin
        sum_nxt[k*D +: D] = dig_sum;
      end
    end
    last_dig = (cnt_q == CW'(NDIG - 1));
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_dig)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            // Subtraction is a + ~b + ~cin, so op=1 with cin=0 gives a - b.
            b_q     <= op ? ~b : b;
            carry_q <= cin ^ op;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          sum     <= sum_nxt;
          carry_q <= dig_cout;
          cnt_q   <= cnt_q + CW'(1);
          if (last_dig) begin
            cout <= dig_cout;
            ovf  <= carry_into_msb ^ dig_cout;
            zero <= (sum_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_add_sub.sv
module tb_digit_serial_add_sub;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic       cin, op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout, ovf, zero;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  digit_serial_add_sub #(.N(8), .D(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: compare every handed-off result with the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else if (out_ready) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sum",  {24'd0, sum},  {24'd0, e.sum});
        chk("cout", {31'd0, cout}, {31'd0, e.cout});
        chk("ovf",  {31'd0, ovf},  {31'd0, e.ovf});
        chk("zero", {31'd0, zero}, {31'd0, e.zero});
      end
    end
  end

  // Issue one operation, expect it in the scoreboard, and measure latency.
  // Returns at posedge+1 of the edge where out_valid first becomes visible.
  task automatic issue(input logic [7:0] ta, input logic [7:0] tb_, input logic tcin,
                       input logic top, input exp_t e);
    int waitc;
    int lat;
    exp_q.push_back(e);
    a = ta; b = tb_; cin = tcin; op = top; in_valid = 1'b1;
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (waitc >= 50) chk("in_ready_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 32'd4);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum",       {24'd0, sum},       32'h00);
    chk("rst_flags",     {29'd0, cout, ovf, zero}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors: {sum, cout, ovf, zero}
    issue(8'h0F, 8'h01, 1'b0, 1'b0, '{8'h10, 1'b0, 1'b0, 1'b0});
    wait_idle();
    issue(8'hF0, 8'hF0, 1'b0, 1'b1, '{8'h00, 1'b1, 1'b0, 1'b1});
    wait_idle();
    issue(8'h7F, 8'h01, 1'b0, 1'b0, '{8'h80, 1'b0, 1'b1, 1'b0});
    wait_idle();
    issue(8'h0A, 8'h05, 1'b1, 1'b0, '{8'h10, 1'b0, 1'b0, 1'b0});
    wait_idle();

    // Backpressure: sub 0x80 - 0x01 held for 3 cycles with new operands pending.
    out_ready = 1'b0;
    issue(8'h80, 8'h01, 1'b0, 1'b1, '{8'h7F, 1'b1, 1'b1, 1'b0});
    exp_q.push_back('{8'h33, 1'b0, 1'b0, 1'b0});
    a = 8'h11; b = 8'h22; cin = 1'b0; op = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_sum",       {24'd0, sum},       32'h7F);
      chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;                     // handoff edge
    chk("bp_ready_after_handoff", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;                     // acceptance edge
    in_valid = 1'b0;
    chk("bp_accepted", {31'd0, in_ready}, 32'd0);
    begin
      int lat = 0;
      while (!out_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("bp_latency", lat, 32'd4);
    end
    wait_idle();

    // Reset in the 2nd RUN cycle of 0xFF + 0x01.
    a = 8'hFF; b = 8'h01; cin = 1'b0; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;                     // E0: accept
    in_valid = 1'b0;
    @(posedge clk); #1;                     // E1: now in 2nd RUN cycle
    rst = 1'b1;
    #1;
    chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_sum",       {24'd0, sum},       32'h00);
    chk("abort_flags",     {29'd0, cout, ovf, zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
    end
    issue(8'h03, 8'h04, 1'b0, 1'b0, '{8'h07, 1'b0, 1'b0, 1'b0});
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/digit_serial_add_sub.md
# digit_serial_add_sub

Parametrised, multi-cycle adder/subtractor with valid/ready handshakes. It processes an N-bit operand pair D bits per clock, least-significant digit first, and returns sum, carry-out, signed-overflow and zero flags. It is the area-lean, width-generalised successor to the combinational ripple-carry add/sub datapath. It sits between an operand source and a result consumer in the ALU path.

## Interface
- N, 8, operand/result width in bits; N >= 2.
- D, 2, digit width (bits processed per cycle); 1 <= D <= N, N % D == 0.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair a/b/cin/op presented.
- in_ready  out  1  block can accept operands; combinationally equal to (state == IDLE).
- a  in  N  operand A.
- b  in  N  operand B.
- cin  in  1  carry-in.
- op  in  1  0 = add; 1 = subtract.
- out_valid  out  1  result registers valid; equal to (state == DONE).
- out_ready  in  1  consumer takes result.
- sum  out  N  result.
- cout  out  1  carry out of bit N-1.
- ovf  out  1  signed overflow: carry into bit N-1 XOR carry out of bit N-1.
- zero  out  1  sum == 0.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - in_valid & in_ready at an edge captures a, b, cin and op, clears the digit counter, and moves to RUN.
  - If op = 1, capture b as ~b and cin as ~cin. Subtract with cin = 0 therefore yields a - b in two's complement.
- **RUN**
  - Each edge adds digit k (bits k*D+D-1 : k*D) of the latched A and effective B plus the carry register.
  - Writes the D result bits into sum[k*D+D-1 : k*D] and updates the carry register.
  - k counts 0 to N/D-1.
  - On the edge processing digit N/D-1:
    - register cout;
    - register ovf from the carry into bit N-1 (internal to the last digit) XOR cout;
    - register zero from the full sum;
    - move to DONE.
- **DONE**
  - sum, cout, ovf and zero are held stable.
  - out_valid & out_ready at an edge moves to IDLE.
  - Outputs keep their values until the next result overwrites them.
- Inputs a, b, cin, op and in_valid are ignored outside the accepting edge. Changing them during RUN or DONE has no effect.
- No back-to-back overlap: in_ready is low in RUN and DONE.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, so in_ready = 1;
  - out_valid = 0;
  - sum = 0, cout = 0, ovf = 0, zero = 0;
  - carry register and digit counter cleared.
- Latency: the acceptance edge is E0. RUN occupies edges E1 to E(N/D). out_valid is high after edge E(N/D), i.e. N/D cycles after acceptance.
  - N=8, D=2: 4 cycles.
  - D = N: 1 cycle.
- Minimum throughput: one operation per N/D + 2 cycles (accept, N/D digits, handoff).
- If out_ready is held high, DONE lasts exactly one cycle. in_ready rises the cycle after the handoff edge.
- Reset asserted mid-RUN or in DONE:
  - abort immediately and apply the reset values;
  - any pending result is lost;
  - no out_valid pulse after reset release.
- in_valid asserted during reset is not accepted. The first acceptance can occur at the first rising edge after rst deasserts.

## Test plan
- Reset, then idle: in_ready = 1, out_valid = 0, sum = 0x00, cout = ovf = zero = 0.
- Add a=0x0F, b=0x01, cin=0, op=0 (N=8, D=2):
  - out_valid exactly 4 cycles after acceptance;
  - sum = 0x10, cout = 0, ovf = 0, zero = 0.
- Sub a=0xF0, b=0xF0, cin=0, op=1 → sum = 0x00, cout = 1, ovf = 0, zero = 1.
- Signed overflow cases:
  - add 0x7F + 0x01 → sum = 0x80, cout = 0, ovf = 1;
  - sub 0x80 - 0x01 → sum = 0x7F, cout = 1, ovf = 1.
- Backpressure: hold out_ready = 0 for 3 cycles after out_valid, and drive in_valid = 1 with new operands throughout.
  - Result stays constant and in_ready stays 0.
  - The new operands are not accepted until the cycle after out_ready is taken.
- Reset pulse on the 2nd RUN cycle of add 0xFF + 0x01:
  - all outputs return to reset values immediately;
  - no out_valid follows;
  - a fresh add 0x03 + 0x04 then yields 0x07.
